trap_ctrl: RTL
==============

Name: trap_ctrl

Overview:
- Sequences every context switch into the CSR file: collects synchronous exceptions and machine-level interrupt requests, and picks one by fixed priority.
- Drains the pipeline, then issues a single-cycle CS strobe with CAUSE and NPC.
- Holds off new traps until the CSR file signals the PC redirect.
- Sits between the decode/execute stages and the CSR file.

Parameters:
- XLEN, 64, width of CAUSE and PC values.
- DRAIN_TIMEOUT, 16, maximum cycles to wait for PIPE_EMPTY before forcing the trap.
- ACK_TIMEOUT, 8, maximum cycles to wait for REDIRECT_ACK before raising TRAP_ERR.

Ports:
- CLK  in  1  core clock
- RESET  in  1  asynchronous, active-high reset
- EXC_VALID  in  1  synchronous exception from execute, single-cycle pulse
- EXC_CODE  in  4  exception code (0..15)
- EXC_PC  in  XLEN  PC of the faulting instruction
- IRQ_EXT  in  1  machine external interrupt, level
- IRQ_SW  in  1  machine software interrupt, level
- IRQ_TMR  in  1  machine timer interrupt, level
- MSTATUS_MIE  in  1  global interrupt enable (mstatus bit 3)
- MIE_MASK  in  12  per-cause enable (mie[11:0])
- RETIRE_NPC  in  XLEN  next PC of the youngest retired instruction
- PIPE_EMPTY  in  1  pipeline holds no in-flight instructions
- REDIRECT_ACK  in  1  CSR file has loaded the trap PC, single-cycle pulse
- FLUSH  out  1  stall fetch and kill younger instructions
- CS  out  1  context-switch strobe to the CSR file
- CAUSE  out  XLEN  cause value presented with CS
- NPC  out  XLEN  return PC presented with CS
- BUSY  out  1  controller not idle
- TRAP_ERR  out  1  sticky; REDIRECT_ACK timed out

Behaviour:
- Reset (asynchronous): state IDLE. All outputs 0. Latched cause, NPC and counters 0.
- Interrupt enable: IRQ_EXT, IRQ_SW and IRQ_TMR are each qualified by their MIE_MASK bit (11, 3, 7 respectively) and by MSTATUS_MIE.
- Priority: exception first, then EXT, then SW, then TMR.
- CAUSE encoding:
  - Exception: bit 63 = 0, bits[3:0] = EXC_CODE.
  - Interrupt: bit 63 = 1, bits[3:0] = 11, 3 or 7.
  - All other bits 0.
- NPC source: EXC_PC for an exception, RETIRE_NPC for an interrupt. The value is sampled in the accepting cycle.
- IDLE:
  - On any qualified request, latch CAUSE/NPC and go to DRAIN.
  - If an exception and an interrupt arrive in the same cycle, the exception wins. The interrupt stays pending because it is level-sensitive.
- DRAIN:
  - FLUSH = 1.
  - Counter increments each cycle.
  - Go to ISSUE when PIPE_EMPTY = 1 or the counter reaches DRAIN_TIMEOUT-1.
  - An exception that was latched from IDLE is kept. EXC_VALID pulses arriving in DRAIN are discarded, since they come from killed instructions.
- ISSUE:
  - CS = 1 for exactly one cycle, with CAUSE and NPC stable.
  - FLUSH stays 1.
  - Always go to WAIT_ACK next.
- WAIT_ACK:
  - FLUSH = 1. Counter restarts from 0.
  - On REDIRECT_ACK go to IDLE. FLUSH drops in that same cycle's next edge.
  - If the counter reaches ACK_TIMEOUT-1, set TRAP_ERR (cleared only by RESET) and go to IDLE.
- CAUSE and NPC hold their last value in IDLE.
- BUSY = 1 in every state except IDLE.
- Minimum latency with PIPE_EMPTY already 1: request in cycle 0; CS in cycle 2 (DRAIN in cycle 1, ISSUE in cycle 2).
- REDIRECT_ACK arriving outside WAIT_ACK is ignored.
- A mid-operation RESET returns to IDLE immediately. CS must not be asserted in that cycle.
- Back-to-back traps: a request already present in IDLE's first cycle is accepted immediately.
- Counters saturate and never wrap.

Decomposition:
- Shared package trap_pkg holds:
  - state encoding (IDLE, DRAIN, ISSUE, WAIT_ACK);
  - interrupt cause constants (CAUSE_MEI = 11, CAUSE_MSI = 3, CAUSE_MTI = 7);
  - the interrupt-flag bit position (XLEN-1).
- Natural sub-module: trap_prio_enc. It is the combinational qualifier and priority encoder, producing a valid flag, a 64-bit cause and a select for the NPC source.

Test Plan:
- EXC_VALID with EXC_CODE = 2, EXC_PC = 0x1000, PIPE_EMPTY = 1 -> CS pulses in cycle 2 with CAUSE = 0x2 and NPC = 0x1000. REDIRECT_ACK in cycle 4 -> BUSY = 0 in cycle 5.
- IRQ_TMR = 1, MIE_MASK[7] = 1, MSTATUS_MIE = 1, RETIRE_NPC = 0x2004 -> CAUSE = 0x8000_0000_0000_0007 and NPC = 0x2004. Repeat with MSTATUS_MIE = 0 -> no CS ever.
- Same cycle EXC_VALID (code 5) plus IRQ_EXT -> first CS carries CAUSE = 0x5. After the ACK, a second trap follows with CAUSE = 0x8000_0000_0000_000B.
- IRQ_EXT, IRQ_SW and IRQ_TMR all high and enabled -> CAUSE low bits = 11. Drop IRQ_EXT -> next trap has low bits = 3.
- PIPE_EMPTY held 0 -> CS asserts exactly DRAIN_TIMEOUT+1 cycles after the request. REDIRECT_ACK withheld -> TRAP_ERR = 1 after ACK_TIMEOUT cycles, then IDLE.
- RESET asserted asynchronously during DRAIN -> FLUSH, BUSY and CS = 0 immediately. No CS after release unless a new request arrives.

Source files
------------

// File: rtl/trap_pkg.sv
// Shared encodings for the trap controller: FSM states, interrupt cause codes
// and the position of the interrupt flag inside CAUSE.
package trap_pkg;

    localparam int TRAP_XLEN = 64;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        ISSUE,
        WAIT_ACK
    } trap_state_e;

    localparam logic [3:0] CAUSE_MEI = 4'd11;
    localparam logic [3:0] CAUSE_MSI = 4'd3;
    localparam logic [3:0] CAUSE_MTI = 4'd7;

    // The interrupt flag is always the MSB of CAUSE, whatever XLEN is.
    function automatic int irq_flag_bit(input int xlen);
        return xlen - 1;
    endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Bundle between the pipeline/CSR file and the trap controller; names are
// written from the controller's point of view.
interface trap_ctrl_if #(
    parameter int XLEN = 64
);
    logic            i_exc_valid;
    logic [3:0]      i_exc_code;
    logic [XLEN-1:0] i_exc_pc;
    logic            i_irq_ext;
    logic            i_irq_sw;
    logic            i_irq_tmr;
    logic            i_mstatus_mie;
    logic [11:0]     i_mie_mask;
    logic [XLEN-1:0] i_retire_npc;
    logic            i_pipe_empty;
    logic            i_redirect_ack;

    logic            o_flush;
    logic            o_cs;
    logic [XLEN-1:0] o_cause;
    logic [XLEN-1:0] o_npc;
    logic            o_busy;
    logic            o_trap_err;

    modport master (
        output i_exc_valid, i_exc_code, i_exc_pc, i_irq_ext, i_irq_sw, i_irq_tmr,
               i_mstatus_mie, i_mie_mask, i_retire_npc, i_pipe_empty, i_redirect_ack,
        input  o_flush, o_cs, o_cause, o_npc, o_busy, o_trap_err
    );

    modport slave (
        input  i_exc_valid, i_exc_code, i_exc_pc, i_irq_ext, i_irq_sw, i_irq_tmr,
               i_mstatus_mie, i_mie_mask, i_retire_npc, i_pipe_empty, i_redirect_ack,
        output o_flush, o_cs, o_cause, o_npc, o_busy, o_trap_err
    );

endinterface

// File: rtl/trap_prio_enc.sv
// Qualifies interrupt requests with their enables and picks the winning trap:
// exception, then external, software, timer interrupt.
module trap_prio_enc
    import trap_pkg::*;
#(
    parameter int XLEN = TRAP_XLEN
) (
    input  logic            i_exc_valid,
    input  logic [3:0]      i_exc_code,
    input  logic            i_irq_ext,
    input  logic            i_irq_sw,
    input  logic            i_irq_tmr,
    input  logic            i_mstatus_mie,
    input  logic [11:0]     i_mie_mask,
    output logic            o_valid,
    output logic [XLEN-1:0] o_cause,
    output logic            o_sel_exc
);

    logic w_ext;
    logic w_sw;
    logic w_tmr;
    logic w_unused_mask;

    assign w_ext = i_irq_ext & i_mie_mask[CAUSE_MEI] & i_mstatus_mie;
    assign w_sw  = i_irq_sw  & i_mie_mask[CAUSE_MSI] & i_mstatus_mie;
    assign w_tmr = i_irq_tmr & i_mie_mask[CAUSE_MTI] & i_mstatus_mie;

    // Only the three machine-level interrupt enables exist in this core.
    assign w_unused_mask = ^{i_mie_mask[10:8], i_mie_mask[6:4], i_mie_mask[2:0]};

    always_comb begin
        o_valid   = 1'b0;
        o_cause   = '0;
        o_sel_exc = 1'b0;
        if (i_exc_valid) begin
            o_valid      = 1'b1;
            o_sel_exc    = 1'b1;
            o_cause[3:0] = i_exc_code;
        end else if (w_ext || w_sw || w_tmr) begin
            o_valid                      = 1'b1;
            o_cause[irq_flag_bit(XLEN)]  = 1'b1;
            o_cause[3:0]                 = w_ext ? CAUSE_MEI : (w_sw ? CAUSE_MSI : CAUSE_MTI);
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: accepts one qualified trap, drains the pipeline, strobes CS
// into the CSR file and holds off further traps until the PC redirect.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int XLEN          = TRAP_XLEN,
    parameter int DRAIN_TIMEOUT = 16,
    parameter int ACK_TIMEOUT   = 8
) (
    input logic        i_clk,
    input logic        i_rst,
    trap_ctrl_if.slave bus
);

    localparam int CNT_MAX = (DRAIN_TIMEOUT > ACK_TIMEOUT) ? DRAIN_TIMEOUT : ACK_TIMEOUT;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_TIMEOUT - 1);

    logic            w_valid;
    logic [XLEN-1:0] w_cause;
    logic            w_sel_exc;

    trap_state_e     r_state;
    logic [CNT_W-1:0] r_cnt;
    logic            r_flush;
    logic            r_cs;
    logic            r_busy;
    logic            r_trap_err;
    logic [XLEN-1:0] r_cause;
    logic [XLEN-1:0] r_npc;

    trap_prio_enc #(.XLEN(XLEN)) u_prio (
        .i_exc_valid   (bus.i_exc_valid),
        .i_exc_code    (bus.i_exc_code),
        .i_irq_ext     (bus.i_irq_ext),
        .i_irq_sw      (bus.i_irq_sw),
        .i_irq_tmr     (bus.i_irq_tmr),
        .i_mstatus_mie (bus.i_mstatus_mie),
        .i_mie_mask    (bus.i_mie_mask),
        .o_valid       (w_valid),
        .o_cause       (w_cause),
        .o_sel_exc     (w_sel_exc)
    );

    // Requests are only looked at in IDLE, so exceptions from killed
    // instructions during DRAIN/WAIT_ACK fall away on their own.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_flush    <= 1'b0;
            r_cs       <= 1'b0;
            r_busy     <= 1'b0;
            r_trap_err <= 1'b0;
            r_cause    <= '0;
            r_npc      <= '0;
        end else begin
            r_cs <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_cause <= w_cause;
                        r_npc   <= w_sel_exc ? bus.i_exc_pc : bus.i_retire_npc;
                        r_cnt   <= '0;
                        r_flush <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus.i_pipe_empty || (r_cnt == DRAIN_LAST)) begin
                        r_cs    <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= ISSUE;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (bus.i_redirect_ack || (r_cnt == ACK_LAST)) begin
                        if (!bus.i_redirect_ack) begin
                            r_trap_err <= 1'b1;
                        end
                        r_flush <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.o_flush    = r_flush;
    assign bus.o_cs       = r_cs;
    assign bus.o_busy     = r_busy;
    assign bus.o_trap_err = r_trap_err;
    assign bus.o_cause    = r_cause;
    assign bus.o_npc      = r_npc;

endmodule
